// File: rtl/contadores_envase.sv
// ============================================================================
//  Module   : contadores_envase
//  Brief    : Bottling-line counter core: conditions four raw inputs and keeps
//             bottle, box (dozen) and cork-stock counters plus conveyor flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module contadores_envase #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int RECARGA_ROLHAS  = 20,
    parameter int ROLHAS_INICIAL  = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor_garrafa,
    input  logic       caixa_retirada,
    input  logic       recarga_rolhas,
    input  logic       reset_lote,
    output logic [3:0] count_garrafas,
    output logic [3:0] count_duzias,
    output logic [6:0] count_rolhas,
    output logic       parar_esteira,
    output logic       falta_rolha,
    output logic       lote_completo
);

    localparam int         c_GARRAFA  = 0;
    localparam int         c_CAIXA    = 1;
    localparam int         c_RECARGA  = 2;
    localparam int         c_LOTE     = 3;
    localparam logic [7:0] c_DEB_LAST = 8'(DEBOUNCE_CICLOS - 1);
    localparam logic [7:0] c_REC_QTD  = 8'(RECARGA_ROLHAS);
    localparam logic [6:0] c_ROL_INI  = 7'(ROLHAS_INICIAL);
    localparam logic [7:0] c_ROL_MAX  = 8'd99;

    localparam logic [1:0] c_OPERANDO      = 2'd0;
    localparam logic [1:0] c_CAIXA_CHEIA   = 2'd1;
    localparam logic [1:0] c_LOTE_COMPLETO = 2'd2;

    logic [3:0] w_raw;
    logic [3:0] w_ev;

    assign w_raw = {reset_lote, recarga_rolhas, caixa_retirada, sensor_garrafa};

    // Per input: 2-FF synchronizer, debounce filter, registered rising-edge pulse.
    for (genvar gi = 0; gi < 4; gi++) begin : g_cond
        logic       r_sync1;
        logic       r_sync2;
        logic       r_filt;
        logic       r_filt_d;
        logic       r_ev;
        logic [7:0] r_cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_filt   <= 1'b0;
                r_filt_d <= 1'b0;
                r_ev     <= 1'b0;
                r_cnt    <= 8'd0;
            end else begin
                r_sync1 <= w_raw[gi];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_filt) begin
                    r_cnt <= 8'd0;
                end else if (r_cnt == c_DEB_LAST) begin
                    r_filt <= ~r_filt;
                    r_cnt  <= 8'd0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
                r_filt_d <= r_filt;
                r_ev     <= r_filt & ~r_filt_d;
            end
        end

        assign w_ev[gi] = r_ev;
    end

    logic [1:0] r_state;
    logic [3:0] r_garrafas;
    logic [3:0] r_duzias;
    logic [6:0] r_rolhas;
    logic       r_parar;
    logic       r_falta;
    logic       r_lote;

    logic [1:0] w_state_nx;
    logic [3:0] w_gar_nx;
    logic [3:0] w_duz_nx;
    logic [6:0] w_rol_nx;
    logic       w_aceita;
    logic [7:0] w_soma;

    always_comb begin
        w_state_nx = r_state;
        w_gar_nx   = r_garrafas;
        w_duz_nx   = r_duzias;
        w_rol_nx   = r_rolhas;
        w_aceita   = 1'b0;
        w_soma     = 8'd0;
        if (w_ev[c_LOTE]) begin
            w_state_nx = c_OPERANDO;
            w_gar_nx   = 4'd0;
            w_duz_nx   = 4'd0;
            w_rol_nx   = c_ROL_INI;
        end else begin
            case (r_state)
                c_OPERANDO: begin
                    if (w_ev[c_GARRAFA] && (r_rolhas != 7'd0)) begin
                        w_aceita = 1'b1;
                        w_gar_nx = r_garrafas + 4'd1;
                        if (r_garrafas == 4'd11) w_state_nx = c_CAIXA_CHEIA;
                    end
                end
                c_CAIXA_CHEIA: begin
                    if (w_ev[c_CAIXA]) begin
                        w_gar_nx   = 4'd0;
                        w_duz_nx   = r_duzias + 4'd1;
                        w_state_nx = (r_duzias == 4'd9) ? c_LOTE_COMPLETO : c_OPERANDO;
                    end
                end
                default: ;
            endcase
            // Stock is never 0 when a bottle is accepted, so the subtraction cannot wrap.
            w_soma = {1'b0, r_rolhas} - {7'd0, w_aceita}
                   + (w_ev[c_RECARGA] ? c_REC_QTD : 8'd0);
            w_rol_nx = (w_soma > c_ROL_MAX) ? c_ROL_MAX[6:0] : w_soma[6:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_OPERANDO;
            r_garrafas <= 4'd0;
            r_duzias   <= 4'd0;
            r_rolhas   <= c_ROL_INI;
            r_parar    <= 1'b0;
            r_falta    <= 1'b0;
            r_lote     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_garrafas <= w_gar_nx;
            r_duzias   <= w_duz_nx;
            r_rolhas   <= w_rol_nx;
            r_falta    <= (w_rol_nx == 7'd0);
            r_parar    <= (w_state_nx != c_OPERANDO) || (w_rol_nx == 7'd0);
            r_lote     <= (w_state_nx == c_LOTE_COMPLETO);
        end
    end

    assign count_garrafas = r_garrafas;
    assign count_duzias   = r_duzias;
    assign count_rolhas   = r_rolhas;
    assign parar_esteira  = r_parar;
    assign falta_rolha    = r_falta;
    assign lote_completo  = r_lote;

endmodule

`default_nettype wire

// File: tb/tb_contadores_envase.sv
// ============================================================================
//  Module   : tb_contadores_envase
//  Brief    : Randomized and directed bench for contadores_envase with a
//             behavioural reference model of conditioning and counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_contadores_envase;

    localparam int c_DEB = 4;
    localparam int c_REC = 20;
    localparam int c_INI = 50;

    logic       clk;
    logic       reset_n;
    logic       sensor_garrafa;
    logic       caixa_retirada;
    logic       recarga_rolhas;
    logic       reset_lote;
    logic [3:0] count_garrafas;
    logic [3:0] count_duzias;
    logic [6:0] count_rolhas;
    logic       parar_esteira;
    logic       falta_rolha;
    logic       lote_completo;

    contadores_envase #(
        .DEBOUNCE_CICLOS(c_DEB),
        .RECARGA_ROLHAS (c_REC),
        .ROLHAS_INICIAL (c_INI)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sensor_garrafa(sensor_garrafa),
        .caixa_retirada(caixa_retirada),
        .recarga_rolhas(recarga_rolhas),
        .reset_lote    (reset_lote),
        .count_garrafas(count_garrafas),
        .count_duzias  (count_duzias),
        .count_rolhas  (count_rolhas),
        .parar_esteira (parar_esteira),
        .falta_rolha   (falta_rolha),
        .lote_completo (lote_completo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw history window, "last N synced samples all differ"
    // filter rule, fixed event delay, and the counting rules in plain integers.
    logic [3:0] q_raw[$];
    logic [3:0] q_seen[$];
    logic [3:0] m_filt, m_d1, m_d2;
    int m_gar, m_duz, m_rol, m_st;  // m_st: 0 operating, 1 box full, 2 lot complete

    task automatic m_reset();
        q_raw.delete();
        q_seen.delete();
        m_filt = '0; m_d1 = '0; m_d2 = '0;
        m_gar = 0; m_duz = 0; m_rol = c_INI; m_st = 0;
    endtask

    task automatic m_core(input logic [3:0] ev);
        int acc;
        acc = 0;
        if (ev[3]) begin
            m_gar = 0; m_duz = 0; m_rol = c_INI; m_st = 0;
        end else begin
            if (m_st == 1 && ev[1]) begin
                m_gar = 0;
                m_duz = m_duz + 1;
                m_st = (m_duz == 10) ? 2 : 0;
            end else if (m_st == 0 && ev[0] && m_rol > 0) begin
                acc = 1;
                m_gar = m_gar + 1;
                if (m_gar == 12) m_st = 1;
            end
            m_rol = m_rol - acc + (ev[2] ? c_REC : 0);
            if (m_rol > 99) m_rol = 99;
        end
    endtask

    task automatic m_edge(input logic [3:0] raw);
        logic [3:0] seen, rose, ev;
        bit all_diff;
        q_raw.push_back(raw);
        if (q_raw.size() > 3) void'(q_raw.pop_front());
        seen = (q_raw.size() == 3) ? q_raw[0] : 4'd0;
        q_seen.push_back(seen);
        if (q_seen.size() > c_DEB) void'(q_seen.pop_front());
        rose = '0;
        for (int i = 0; i < 4; i++) begin
            if (q_seen.size() == c_DEB) begin
                all_diff = 1'b1;
                foreach (q_seen[j]) if (q_seen[j][i] == m_filt[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_filt[i] = ~m_filt[i];
                    if (m_filt[i]) rose[i] = 1'b1;
                end
            end
        end
        ev = m_d2; m_d2 = m_d1; m_d1 = rose;
        m_core(ev);
    endtask

    task automatic chk_all();
        chk("garrafas", int'(count_garrafas), m_gar);
        chk("duzias",   int'(count_duzias),   m_duz);
        chk("rolhas",   int'(count_rolhas),   m_rol);
        chk("falta",    int'(falta_rolha),    (m_rol == 0) ? 1 : 0);
        chk("parar",    int'(parar_esteira),  (m_st != 0 || m_rol == 0) ? 1 : 0);
        chk("lote",     int'(lote_completo),  (m_st == 2) ? 1 : 0);
    endtask

    task automatic step(input logic [3:0] raw);
        sensor_garrafa = raw[0];
        caixa_retirada = raw[1];
        recarga_rolhas = raw[2];
        reset_lote     = raw[3];
        @(posedge clk);
        m_edge(raw);
        #1;
        chk_all();
    endtask

    task automatic press(input logic [3:0] mask, input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(mask);
        for (int i = 0; i < lo; i++) step(4'd0);
    endtask

    task automatic bottle(); press(4'b0001, 6, 7); endtask
    task automatic caixa();  press(4'b0010, 6, 7); endtask
    task automatic recarga(); press(4'b0100, 6, 7); endtask
    task automatic lote();   press(4'b1000, 6, 7); endtask

    task automatic async_reset();
        sensor_garrafa = 0; caixa_retirada = 0; recarga_rolhas = 0; reset_lote = 0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        m_reset();
        #1;
        chk("rst_garrafas", int'(count_garrafas), 0);
        chk("rst_duzias",   int'(count_duzias),   0);
        chk("rst_rolhas",   int'(count_rolhas),   c_INI);
        chk("rst_flags",    int'({parar_esteira, falta_rolha, lote_completo}), 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic fill_box();
        for (int n = 0; n < 20 && m_gar < 12; n++) begin
            if (m_st == 2) lote();
            if (m_rol < 13) recarga();
            bottle();
        end
    endtask

    task automatic go_rolhas(input int target);
        for (int n = 0; n < 300 && m_rol != target; n++) begin
            if (m_rol < target) recarga();
            else if (m_st == 1) caixa();
            else if (m_st == 2) lote();
            else bottle();
        end
        chk("go_rolhas", int'(count_rolhas), target);
    endtask

    initial begin
        reset_n = 1'b0;
        sensor_garrafa = 0; caixa_retirada = 0; recarga_rolhas = 0; reset_lote = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all();
        chk("init_rolhas", int'(count_rolhas), c_INI);
        @(negedge clk);
        reset_n = 1'b1;

        // Glitch, clean pulse, bouncy pulse.
        press(4'b0001, 3, 8);
        chk("glitch_garrafas", int'(count_garrafas), 0);
        press(4'b0001, 6, 7);
        chk("clean_garrafas", int'(count_garrafas), 1);
        chk("clean_rolhas",   int'(count_rolhas), 49);
        step(4'b0001); step(4'b0000); step(4'b0001); step(4'b0000);
        press(4'b0001, 6, 7);
        chk("bounce_garrafas", int'(count_garrafas), 2);

        // Full box, ignored 13th bottle, removal.
        fill_box();
        chk("box_rolhas", int'(count_rolhas), 38);
        bottle();
        chk("box13_garrafas", int'(count_garrafas), 12);
        caixa();
        chk("box_duzias", int'(count_duzias), 1);

        bottle();
        async_reset();

        // Ten boxes to complete the lot.
        for (int b = 0; b < 15 && m_st != 2; b++) begin
            fill_box();
            caixa();
        end
        chk("lote_duzias", int'(count_duzias), 10);
        chk("lote_flag", int'(lote_completo), 1);
        bottle();
        caixa();
        chk("lote_hold", int'(count_garrafas), 0);
        lote();
        chk("lote_reset_rolhas", int'(count_rolhas), c_INI);

        // Drain corks, refill, saturate.
        go_rolhas(0);
        chk("falta", int'(falta_rolha), 1);
        if (m_st == 0) bottle();
        recarga();
        chk("recarga_rolhas", int'(count_rolhas), 20);
        go_rolhas(90);
        recarga();
        chk("saturado", int'(count_rolhas), 99);

        // Simultaneous bottle and refill, then lot reset against box removal.
        if (m_st != 0) lote();
        go_rolhas(85);
        if (m_st != 0) begin lote(); go_rolhas(85); end
        press(4'b0101, 6, 7);
        chk("simult_rolhas", int'(count_rolhas), 99);
        fill_box();
        press(4'b1010, 6, 7);
        chk("lote_caixa_duzias", int'(count_duzias), 0);

        // Random pulses of mixed length, overlap and occasional async reset.
        for (int it = 0; it < 400; it++) begin
            logic [3:0] mask;
            int r;
            r = $urandom_range(0, 99);
            if      (r < 55) mask = 4'b0001;
            else if (r < 70) mask = 4'b0010;
            else if (r < 82) mask = 4'b0100;
            else if (r < 85) mask = 4'b1000;
            else             mask = 4'($urandom_range(1, 15));
            press(mask, $urandom_range(1, 8), $urandom_range(1, 8));
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
